// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI-lite arbiter.
// Contents: default bus widths, FSM state encoding, one-hot grant codes.
package axi_arb_pkg;

  localparam int ARB_ADDR_W = 3;
  localparam int ARB_DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-requester picker.
// Ports: req[1:0] request per master, prio = master favoured on contention,
//        gnt[1:0] one-hot winner (GNT_NONE when nobody requests).
// Build option ARB_FIXED_PRIO_EN: master 0 always wins and prio is ignored.
module rr_pick2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
`ifdef ARB_FIXED_PRIO_EN
    if (req[0])      gnt = GNT_M0;
    else if (req[1]) gnt = GNT_M1;
`else
    if (req == 2'b11) gnt = prio ? GNT_M1 : GNT_M0;
    else              gnt = req;
`endif
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master / one-slave AXI-lite arbiter. One whole transaction (AW+W+B or
// AR+R) is owned by one master at a time; writes beat reads within a master.
// Ports: clk, rst (sync, active-high); m0_*/m1_* master-side channels;
//        s_* slave-side channels; grant (one-hot owner, 0 when idle);
//        busy (not IDLE); state (FSM state, debug visibility).
// Handshake: a channel transfers on a cycle where valid and ready are both
//        high; forwarded valid/ready pass straight through the granted path.
// Build option ARB_FIXED_PRIO_EN: fixed priority for master 0 instead of
//        round-robin.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_aw_valid,
  input  logic [ADDR_W-1:0] m0_aw_addr,
  output logic              m0_aw_ready,
  input  logic              m0_w_valid,
  input  logic [DATA_W-1:0] m0_w_data,
  output logic              m0_w_ready,
  output logic              m0_b_valid,
  input  logic              m0_b_ready,
  input  logic              m0_ar_valid,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  output logic              m0_ar_ready,
  output logic              m0_r_valid,
  output logic [DATA_W-1:0] m0_r_data,
  input  logic              m0_r_ready,
  input  logic              m1_aw_valid,
  input  logic [ADDR_W-1:0] m1_aw_addr,
  output logic              m1_aw_ready,
  input  logic              m1_w_valid,
  input  logic [DATA_W-1:0] m1_w_data,
  output logic              m1_w_ready,
  output logic              m1_b_valid,
  input  logic              m1_b_ready,
  input  logic              m1_ar_valid,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  output logic              m1_ar_ready,
  output logic              m1_r_valid,
  output logic [DATA_W-1:0] m1_r_data,
  input  logic              m1_r_ready,
  output logic              s_aw_valid,
  output logic [ADDR_W-1:0] s_aw_addr,
  input  logic              s_aw_ready,
  output logic              s_w_valid,
  output logic [DATA_W-1:0] s_w_data,
  input  logic              s_w_ready,
  input  logic              s_b_valid,
  output logic              s_b_ready,
  output logic              s_ar_valid,
  output logic [ADDR_W-1:0] s_ar_addr,
  input  logic              s_ar_ready,
  input  logic              s_r_valid,
  input  logic [DATA_W-1:0] s_r_data,
  output logic              s_r_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [2:0]        state
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_WR_ADDR = WR_ADDR;
  localparam logic [2:0] ST_WR_RESP = WR_RESP;
  localparam logic [2:0] ST_RD_ADDR = RD_ADDR;
  localparam logic [2:0] ST_RD_DATA = RD_DATA;

  logic [2:0] state_q;
  logic [1:0] grant_q;
  logic       aw_done, w_done;
  logic [1:0] req, pick;
  logic       pick_prio;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_prio = 1'b0;
`else
  logic prio_q;
  assign pick_prio = prio_q;
`endif

  assign req = {m1_aw_valid | m1_ar_valid, m0_aw_valid | m0_ar_valid};

  rr_pick2 u_pick (
    .req  (req),
    .prio (pick_prio),
    .gnt  (pick)
  );

  // sel picks master 1's signals; in IDLE everything below is gated off.
  logic sel;
  assign sel = grant_q[1];

  logic              sel_aw_valid, sel_w_valid, sel_b_ready, sel_ar_valid, sel_r_ready;
  logic [ADDR_W-1:0] sel_aw_addr, sel_ar_addr;
  logic [DATA_W-1:0] sel_w_data;

  assign sel_aw_valid = sel ? m1_aw_valid : m0_aw_valid;
  assign sel_aw_addr  = sel ? m1_aw_addr  : m0_aw_addr;
  assign sel_w_valid  = sel ? m1_w_valid  : m0_w_valid;
  assign sel_w_data   = sel ? m1_w_data   : m0_w_data;
  assign sel_b_ready  = sel ? m1_b_ready  : m0_b_ready;
  assign sel_ar_valid = sel ? m1_ar_valid : m0_ar_valid;
  assign sel_ar_addr  = sel ? m1_ar_addr  : m0_ar_addr;
  assign sel_r_ready  = sel ? m1_r_ready  : m0_r_ready;

  logic in_wa, in_wr, in_ra, in_rd;
  assign in_wa = (state_q == ST_WR_ADDR);
  assign in_wr = (state_q == ST_WR_RESP);
  assign in_ra = (state_q == ST_RD_ADDR);
  assign in_rd = (state_q == ST_RD_DATA);

  // A channel that already handshook is masked so no second beat leaks through.
  assign s_aw_valid = in_wa & ~aw_done & sel_aw_valid;
  assign s_aw_addr  = in_wa ? sel_aw_addr : '0;
  assign s_w_valid  = in_wa & ~w_done & sel_w_valid;
  assign s_w_data   = in_wa ? sel_w_data : '0;
  assign s_b_ready  = in_wr & sel_b_ready;
  assign s_ar_valid = in_ra & sel_ar_valid;
  assign s_ar_addr  = in_ra ? sel_ar_addr : '0;
  assign s_r_ready  = in_rd & sel_r_ready;

  logic              aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic [DATA_W-1:0] r_dat;
  assign aw_rdy = in_wa & ~aw_done & s_aw_ready;
  assign w_rdy  = in_wa & ~w_done & s_w_ready;
  assign b_vld  = in_wr & s_b_valid;
  assign ar_rdy = in_ra & s_ar_ready;
  assign r_vld  = in_rd & s_r_valid;
  assign r_dat  = in_rd ? s_r_data : '0;

  assign m0_aw_ready = aw_rdy & ~sel;
  assign m1_aw_ready = aw_rdy & sel;
  assign m0_w_ready  = w_rdy & ~sel;
  assign m1_w_ready  = w_rdy & sel;
  assign m0_b_valid  = b_vld & ~sel;
  assign m1_b_valid  = b_vld & sel;
  assign m0_ar_ready = ar_rdy & ~sel;
  assign m1_ar_ready = ar_rdy & sel;
  assign m0_r_valid  = r_vld & ~sel;
  assign m1_r_valid  = r_vld & sel;
  assign m0_r_data   = sel ? '0 : r_dat;
  assign m1_r_data   = sel ? r_dat : '0;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign aw_fire = s_aw_valid & s_aw_ready;
  assign w_fire  = s_w_valid & s_w_ready;
  assign b_fire  = b_vld & sel_b_ready;
  assign ar_fire = s_ar_valid & s_ar_ready;
  assign r_fire  = r_vld & sel_r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (pick != GNT_NONE) begin
            grant_q <= pick;
            state_q <= (pick[1] ? m1_aw_valid : m0_aw_valid) ? ST_WR_ADDR : ST_RD_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            state_q <= ST_WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (b_fire) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
          end
        end
        ST_RD_ADDR: begin
          if (ar_fire) state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (r_fire) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= GNT_NONE;
        end
      endcase
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // After a completion the other master is favoured next time both ask.
  always_ff @(posedge clk) begin
    if (rst)                  prio_q <= 1'b0;
    else if (b_fire | r_fire) prio_q <= ~sel;
  end
`endif

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
module tb_axi_lite_arbiter;

  localparam int AW = 3;
  localparam int DW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]    aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [AW-1:0] aw_addr [2];
  logic [AW-1:0] ar_addr [2];
  logic [DW-1:0] w_data  [2];
  logic [1:0]    aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [DW-1:0] r_data  [2];

  logic          s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
  logic [AW-1:0] s_aw_addr, s_ar_addr;
  logic [DW-1:0] s_w_data;
  logic          s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
  logic [DW-1:0] s_r_data;
  logic [1:0]    grant;
  logic          busy;
  logic [2:0]    state;

  axi_lite_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_aw_valid(aw_valid[0]), .m0_aw_addr(aw_addr[0]), .m0_aw_ready(aw_ready[0]),
    .m0_w_valid(w_valid[0]),   .m0_w_data(w_data[0]),   .m0_w_ready(w_ready[0]),
    .m0_b_valid(b_valid[0]),   .m0_b_ready(b_ready[0]),
    .m0_ar_valid(ar_valid[0]), .m0_ar_addr(ar_addr[0]), .m0_ar_ready(ar_ready[0]),
    .m0_r_valid(r_valid[0]),   .m0_r_data(r_data[0]),   .m0_r_ready(r_ready[0]),
    .m1_aw_valid(aw_valid[1]), .m1_aw_addr(aw_addr[1]), .m1_aw_ready(aw_ready[1]),
    .m1_w_valid(w_valid[1]),   .m1_w_data(w_data[1]),   .m1_w_ready(w_ready[1]),
    .m1_b_valid(b_valid[1]),   .m1_b_ready(b_ready[1]),
    .m1_ar_valid(ar_valid[1]), .m1_ar_addr(ar_addr[1]), .m1_ar_ready(ar_ready[1]),
    .m1_r_valid(r_valid[1]),   .m1_r_data(r_data[1]),   .m1_r_ready(r_ready[1]),
    .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid),   .s_w_data(s_w_data),   .s_w_ready(s_w_ready),
    .s_b_valid(s_b_valid),   .s_b_ready(s_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid),   .s_r_data(s_r_data),   .s_r_ready(s_r_ready),
    .grant(grant), .busy(busy), .state(state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // own: owning master (-1 none); is_wr: write transaction; aw_hs/w_hs:
  // address/data beats already taken; resp: in the response/data phase.
  int own = -1;
  int rr  = 0;
  bit is_wr, aw_hs, w_hs, resp;
  bit model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      own = -1;
      rr = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (own < 0) begin
        bit r0, r1;
        r0 = aw_valid[0] | ar_valid[0];
        r1 = aw_valid[1] | ar_valid[1];
        if (r0 || r1) begin
`ifdef ARB_FIXED_PRIO_EN
          own = r0 ? 0 : 1;
`else
          own = (r0 && r1) ? rr : (r0 ? 0 : 1);
`endif
          is_wr = aw_valid[own];
          aw_hs = 1'b0; w_hs = 1'b0; resp = 1'b0;
        end
      end else if (is_wr && !resp) begin
        if (aw_valid[own] && !aw_hs && s_aw_ready) aw_hs = 1'b1;
        if (w_valid[own] && !w_hs && s_w_ready) w_hs = 1'b1;
        if (aw_hs && w_hs) resp = 1'b1;
      end else if (is_wr) begin
        if (s_b_valid && b_ready[own]) begin rr = 1 - own; own = -1; end
      end else if (!resp) begin
        if (ar_valid[own] && s_ar_ready) resp = 1'b1;
      end else begin
        if (s_r_valid && r_ready[own]) begin rr = 1 - own; own = -1; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [8:0]    em [2];
  logic          e_aw_v, e_w_v, e_b_r, e_ar_v, e_r_r;
  logic [AW-1:0] e_aw_a, e_ar_a;
  logic [DW-1:0] e_w_d;

  always @(negedge clk) begin
    if (model_on) begin
      em[0] = '0; em[1] = '0;
      {e_aw_v, e_w_v, e_b_r, e_ar_v, e_r_r} = '0;
      e_aw_a = '0; e_ar_a = '0; e_w_d = '0;
      if (own >= 0) begin
        if (is_wr && !resp) begin
          e_aw_v = aw_valid[own] && !aw_hs;
          e_aw_a = aw_addr[own];
          e_w_v  = w_valid[own] && !w_hs;
          e_w_d  = w_data[own];
          em[own] = {s_aw_ready && !aw_hs, s_w_ready && !w_hs, 1'b0, 1'b0, 1'b0, 4'h0};
        end else if (is_wr) begin
          e_b_r  = b_ready[own];
          em[own] = {1'b0, 1'b0, s_b_valid, 1'b0, 1'b0, 4'h0};
        end else if (!resp) begin
          e_ar_v = ar_valid[own];
          e_ar_a = ar_addr[own];
          em[own] = {1'b0, 1'b0, 1'b0, s_ar_ready, 1'b0, 4'h0};
        end else begin
          e_r_r  = r_ready[own];
          em[own] = {1'b0, 1'b0, 1'b0, 1'b0, s_r_valid, s_r_data};
        end
      end
      chk("m0_outputs", 32'({aw_ready[0], w_ready[0], b_valid[0], ar_ready[0], r_valid[0], r_data[0]}), 32'(em[0]));
      chk("m1_outputs", 32'({aw_ready[1], w_ready[1], b_valid[1], ar_ready[1], r_valid[1], r_data[1]}), 32'(em[1]));
      chk("slave_outputs",
          32'({s_aw_valid, s_aw_addr, s_w_valid, s_w_data, s_b_ready, s_ar_valid, s_ar_addr, s_r_ready}),
          32'({e_aw_v, e_aw_a, e_w_v, e_w_d, e_b_r, e_ar_v, e_ar_a, e_r_r}));
      chk("grant_busy", 32'({grant, busy}),
          32'({(own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10), own >= 0}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    aw_valid = '0; w_valid = '0; b_ready = '0; ar_valid = '0; r_ready = '0;
    for (int i = 0; i < 2; i++) begin
      aw_addr[i] = '0; ar_addr[i] = '0; w_data[i] = '0;
    end
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic random_inputs();
    rst = ($urandom_range(0, 99) == 0);
    for (int i = 0; i < 2; i++) begin
      aw_valid[i] = ($urandom_range(0, 2) == 0);
      w_valid[i]  = ($urandom_range(0, 1) == 0);
      ar_valid[i] = ($urandom_range(0, 2) == 0);
      b_ready[i]  = ($urandom_range(0, 2) != 0);
      r_ready[i]  = ($urandom_range(0, 2) != 0);
      aw_addr[i]  = AW'($urandom);
      ar_addr[i]  = AW'($urandom);
      w_data[i]   = DW'($urandom);
    end
    s_aw_ready = ($urandom_range(0, 1) == 0);
    s_w_ready  = ($urandom_range(0, 1) == 0);
    s_b_valid  = ($urandom_range(0, 1) == 0);
    s_ar_ready = ($urandom_range(0, 1) == 0);
    s_r_valid  = ($urandom_range(0, 1) == 0);
    s_r_data   = DW'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    neg();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_s_valids", 32'({s_aw_valid, s_w_valid, s_ar_valid, s_b_ready, s_r_ready}), 32'h0);
    tick(); rst = 1'b0;

    // m0 write addr 5 data A
    aw_valid[0] = 1'b1; aw_addr[0] = 3'd5; w_valid[0] = 1'b1; w_data[0] = 4'hA;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; b_ready[0] = 1'b1;
    neg(); chk("wr_idle_no_fwd", 32'(s_aw_valid), 32'h0);
    tick(); neg();
    chk("wr_aw_fwd", 32'({s_aw_valid, s_aw_addr, s_w_valid, s_w_data}), 32'({1'b1, 3'd5, 1'b1, 4'hA}));
    chk("wr_grant", 32'(grant), 32'h1);
    chk("wr_aw_ready", 32'(aw_ready), 32'h1);
    tick(); aw_valid[0] = 1'b0; w_valid[0] = 1'b0; s_b_valid = 1'b1;
    neg(); chk("wr_b_valid", 32'(b_valid), 32'h1);
    tick(); s_b_valid = 1'b0;
    neg(); chk("wr_back_idle", 32'({grant, busy}), 32'h0);
    tick(); idle_inputs();

    // both masters read after reset
    do_reset();
    ar_valid = 2'b11; ar_addr[0] = 3'd2; ar_addr[1] = 3'd6;
    s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_data = 4'h7; r_ready = 2'b11;
    neg(); chk("rd2_idle_grant", 32'(grant), 32'h0);
    tick(); neg();
    chk("rd2_m0_grant", 32'(grant), 32'h1);
    chk("rd2_m0_addr", 32'({s_ar_valid, s_ar_addr}), 32'({1'b1, 3'd2}));
    tick(); ar_valid[0] = 1'b0;
    neg(); chk("rd2_m0_data", 32'({r_valid, r_data[0], r_data[1]}), 32'({2'b01, 4'h7, 4'h0}));
    tick(); neg(); chk("rd2_gap_grant", 32'(grant), 32'h0);
    tick(); neg();
    chk("rd2_m1_grant", 32'(grant), 32'h2);
    chk("rd2_m1_addr", 32'(s_ar_addr), 32'h6);
    tick(); ar_valid[1] = 1'b0;
    neg(); chk("rd2_m1_data", 32'({r_valid, r_data[1]}), 32'({2'b10, 4'h7}));
    tick(); idle_inputs();

    // slave takes W two cycles before AW
    aw_valid[0] = 1'b1; aw_addr[0] = 3'd1; w_valid[0] = 1'b1; w_data[0] = 4'h3;
    s_w_ready = 1'b1; b_ready[0] = 1'b1;
    neg();
    tick(); neg(); chk("wfirst_w_hs", 32'({s_w_valid, w_ready}), 32'({1'b1, 2'b01}));
    tick(); neg(); chk("wfirst_w_masked", 32'({s_w_valid, w_ready, busy}), 32'({1'b0, 2'b00, 1'b1}));
    tick(); s_aw_ready = 1'b1;
    neg(); chk("wfirst_aw_hs", 32'({s_aw_valid, aw_ready}), 32'({1'b1, 2'b01}));
    tick(); s_aw_ready = 1'b0; aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
    neg(); chk("wfirst_resp", 32'({s_aw_valid, s_b_ready, b_valid}), 32'({1'b0, 1'b1, 2'b00}));
    tick(); s_b_valid = 1'b1;
    neg(); chk("wfirst_b", 32'(b_valid), 32'h1);
    tick(); idle_inputs();

    // m0 presents AW and AR together
    aw_valid[0] = 1'b1; w_valid[0] = 1'b1; ar_valid[0] = 1'b1;
    aw_addr[0] = 3'd4; ar_addr[0] = 3'd7; w_data[0] = 4'h6;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1; b_ready[0] = 1'b1;
    s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_data = 4'h9; r_ready[0] = 1'b1;
    neg();
    tick(); neg(); chk("awar_write_first", 32'({s_aw_valid, s_ar_valid}), 32'({1'b1, 1'b0}));
    tick(); aw_valid[0] = 1'b0; w_valid[0] = 1'b0;
    neg(); chk("awar_b", 32'(b_valid), 32'h1);
    tick(); neg(); chk("awar_gap", 32'(busy), 32'h0);
    tick(); neg(); chk("awar_read", 32'({s_ar_valid, s_ar_addr, grant}), 32'({1'b1, 3'd7, 2'b01}));
    tick(); ar_valid[0] = 1'b0;
    neg(); chk("awar_rdata", 32'({r_valid, r_data[0]}), 32'({2'b01, 4'h9}));
    tick(); idle_inputs();

    // reset while waiting in the read-data phase
    ar_valid[0] = 1'b1; s_ar_ready = 1'b1; r_ready[0] = 1'b1;
    neg();
    tick(); neg();
    tick(); ar_valid[0] = 1'b0;
    neg(); chk("rst_mid_busy", 32'({busy, r_valid}), 32'({1'b1, 2'b00}));
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    neg(); chk("rst_mid_cleared", 32'({grant, busy, s_ar_valid, s_r_ready}), 32'h0);
    tick(); ar_valid[1] = 1'b1; ar_addr[1] = 3'd4; s_r_valid = 1'b1; s_r_data = 4'h5; r_ready[1] = 1'b1;
    neg();
    tick(); neg(); chk("rst_m1_grant", 32'(grant), 32'h2);
    tick(); ar_valid[1] = 1'b0;
    neg(); chk("rst_m1_rdata", 32'({r_valid, r_data[1]}), 32'({2'b10, 4'h5}));
    tick(); idle_inputs();

`ifdef ARB_FIXED_PRIO_EN
    begin
      int m1_wins = 0;
      do_reset();
      ar_valid = 2'b11; s_ar_ready = 1'b1; s_r_valid = 1'b1; r_ready = 2'b11;
      for (int i = 0; i < 30; i++) begin
        neg();
        if (grant == 2'b10) m1_wins++;
        tick();
      end
      chk("fixed_m1_never", 32'(m1_wins), 32'h0);
      idle_inputs();
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      random_inputs();
    end
    tick(); rst = 1'b0; idle_inputs();
    tick();
    neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
